addr_match_engine: RTL

Multi-entry, byte-masked address matcher for the sniffer datapath: compares a 32-bit word stream against `NUM_ENTRIES` programmable patterns of `PATTERN_BYTES` bytes at every byte alignment, frame by frame. It succeeds the single fixed MAC comparator and sits between the packet-word source and the capture filter. It passes data through unchanged with fixed latency, and reports a per-entry match vector at end of frame. Patterns are written by the Atom register interface and double-buffered, so reprogramming never corrupts an in-flight frame.

---
 rtl/addr_match_engine_pkg.sv | 11 +
 rtl/addr_match_engine_if.sv | 42 ++++
 rtl/addr_match_engine_pattern_entry.sv | 74 +++++++
 rtl/addr_match_engine.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/addr_match_engine_pkg.sv
// Shared constants and types for the sniffer address matcher.
package sniffer_pkg;

    localparam int DATA_BYTES_DEF = 4;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } match_state_t;

endpackage

// File: rtl/addr_match_engine_if.sv
// Stream, programming and result signals of the address matcher.
// Mask bit i qualifies the i-th pattern byte on the wire (bit 0 = MSB byte of prog_pattern).
interface addr_match_engine_if
    import sniffer_pkg::*;
#(
    parameter int NUM_ENTRIES   = 4,
    parameter int PATTERN_BYTES = 6,
    parameter int DATA_BYTES    = DATA_BYTES_DEF
) ();
    localparam int IW = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

    logic                       clear;
    logic [8*DATA_BYTES-1:0]    data_in;
    logic                       data_valid;
    logic                       sof;
    logic                       eof;
    logic                       prog_wr;
    logic [IW-1:0]              prog_idx;
    logic [8*PATTERN_BYTES-1:0] prog_pattern;
    logic [PATTERN_BYTES-1:0]   prog_mask;
    logic                       prog_en;
    logic [8*DATA_BYTES-1:0]    data_out;
    logic                       data_out_valid;
    logic [NUM_ENTRIES-1:0]     match_vec;
    logic                       match_any;
    logic                       frame_done;
    logic [NUM_ENTRIES-1:0]     frame_match_vec;

    modport slave (
        input  clear, data_in, data_valid, sof, eof,
        input  prog_wr, prog_idx, prog_pattern, prog_mask, prog_en,
        output data_out, data_out_valid, match_vec, match_any,
        output frame_done, frame_match_vec
    );

    modport master (
        output clear, data_in, data_valid, sof, eof,
        output prog_wr, prog_idx, prog_pattern, prog_mask, prog_en,
        input  data_out, data_out_valid, match_vec, match_any,
        input  frame_done, frame_match_vec
    );
endinterface

// File: rtl/addr_match_engine_pattern_entry.sv
// One pattern entry: shadow/active registers and a masked compare at every
// byte alignment of the newest data word.
module pattern_entry
    import sniffer_pkg::*;
#(
    parameter int PATTERN_BYTES = 6,
    parameter int DATA_BYTES    = DATA_BYTES_DEF
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      prog_wr,
    input  logic [8*PATTERN_BYTES-1:0]                prog_pattern,
    input  logic [PATTERN_BYTES-1:0]                  prog_mask,
    input  logic                                      prog_en,
    input  logic                                      load,
    input  logic                                      cmp_en,
    input  logic [8*(PATTERN_BYTES+DATA_BYTES-1)-1:0] ext,
    input  logic [PATTERN_BYTES+DATA_BYTES-1:0]       ext_valid,
    output logic                                      hit
);
    localparam int EB = PATTERN_BYTES + DATA_BYTES - 1;

    logic [8*PATTERN_BYTES-1:0] shadow_pat_q, shadow_pat_d, active_pat_q, active_pat_d;
    logic [PATTERN_BYTES-1:0]   shadow_mask_q, shadow_mask_d, active_mask_q, active_mask_d;
    logic                       shadow_en_q, shadow_en_d, active_en_q, active_en_d;

    // The active set is loaded from the post-write shadow so a write on the sof cycle is used.
    always_comb begin
        shadow_pat_d  = prog_wr ? prog_pattern : shadow_pat_q;
        shadow_mask_d = prog_wr ? prog_mask    : shadow_mask_q;
        shadow_en_d   = prog_wr ? prog_en      : shadow_en_q;
        active_pat_d  = load ? shadow_pat_d  : active_pat_q;
        active_mask_d = load ? shadow_mask_d : active_mask_q;
        active_en_d   = load ? shadow_en_d   : active_en_q;
    end

    // Only masked bytes must lie inside the current frame; ext byte 0 is the oldest.
    always_comb begin
        logic win_ok;
        hit    = 1'b0;
        win_ok = 1'b0;
        if (cmp_en && active_en_d && (|active_mask_d)) begin
            for (int k = 0; k < DATA_BYTES; k++) begin
                win_ok = 1'b1;
                for (int j = 0; j < PATTERN_BYTES; j++) begin
                    if (active_mask_d[j] &&
                        !(ext_valid[k+j] &&
                          (ext[8*(EB-(k+j))-1 -: 8] == active_pat_d[8*(PATTERN_BYTES-j)-1 -: 8]))) begin
                        win_ok = 1'b0;
                    end
                end
                hit = hit | win_ok;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_pat_q  <= '0;
            shadow_mask_q <= '0;
            shadow_en_q   <= 1'b0;
            active_pat_q  <= '0;
            active_mask_q <= '0;
            active_en_q   <= 1'b0;
        end else begin
            shadow_pat_q  <= shadow_pat_d;
            shadow_mask_q <= shadow_mask_d;
            shadow_en_q   <= shadow_en_d;
            active_pat_q  <= active_pat_d;
            active_mask_q <= active_mask_d;
            active_en_q   <= active_en_d;
        end
    end
endmodule

// File: rtl/addr_match_engine.sv
// Multi-entry byte-masked address matcher with fixed-latency passthrough
// and per-frame match reporting.
module addr_match_engine
    import sniffer_pkg::*;
#(
    parameter int NUM_ENTRIES   = 4,
    parameter int PATTERN_BYTES = 6,
    parameter int DATA_BYTES    = DATA_BYTES_DEF,
    parameter int PIPE_STAGES   = 3
) (
    input logic                 clk,
    input logic                 rst,
    addr_match_engine_if.slave  bus
);
    localparam int DW = 8 * DATA_BYTES;
    localparam int EB = PATTERN_BYTES + DATA_BYTES - 1;
    localparam int HW = 8 * (PATTERN_BYTES - 1);
    localparam int CW = $clog2(PATTERN_BYTES + DATA_BYTES + 1);
    localparam int IW = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

    match_state_t           state_q, state_d;
    logic [8*EB-1:0]        hist_q, hist_d, ext;
    logic [HW-1:0]          hist_keep;
    logic [CW-1:0]          cnt_q, cnt_d, base_cnt;
    logic [EB-1:0]          ext_valid;
    logic [NUM_ENTRIES-1:0] hit;
    logic [NUM_ENTRIES-1:0] match_vec_q, match_vec_d;
    logic [NUM_ENTRIES-1:0] frame_match_vec_q, frame_match_vec_d;
    logic                   frame_done_q, frame_done_d;
    logic                   is_sof, is_eof, cmp_en;

    always_comb begin
        int sum;
        is_sof    = bus.data_valid & bus.sof & ~bus.clear;
        is_eof    = bus.data_valid & bus.eof;
        cmp_en    = bus.data_valid & ~bus.clear & (bus.sof | (state_q == ACTIVE));
        base_cnt  = is_sof ? '0 : cnt_q;
        hist_keep = is_sof ? '0 : hist_q[HW-1:0];
        ext       = {hist_keep, bus.data_in};
        // ext byte e sits at frame offset base_cnt + e - (PATTERN_BYTES-1).
        for (int e = 0; e < EB; e++) begin
            ext_valid[e] = (int'(base_cnt) + e) >= (PATTERN_BYTES - 1);
        end

        sum               = int'(base_cnt) + DATA_BYTES;
        state_d           = state_q;
        hist_d            = hist_q;
        cnt_d             = cnt_q;
        match_vec_d       = match_vec_q;
        frame_done_d      = 1'b0;
        frame_match_vec_d = frame_match_vec_q;
        if (cmp_en) begin
            hist_d       = ext;
            cnt_d        = (sum >= PATTERN_BYTES) ? CW'(PATTERN_BYTES) : CW'(sum);
            match_vec_d  = (is_sof ? '0 : match_vec_q) | hit;
            state_d      = is_eof ? IDLE : ACTIVE;
            frame_done_d = is_eof;
            if (is_eof) begin
                frame_match_vec_d = match_vec_d;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q           <= IDLE;
            hist_q            <= '0;
            cnt_q             <= '0;
            match_vec_q       <= '0;
            frame_done_q      <= 1'b0;
            frame_match_vec_q <= '0;
        end else if (bus.clear) begin
            state_q           <= IDLE;
            hist_q            <= '0;
            cnt_q             <= '0;
            match_vec_q       <= '0;
            frame_done_q      <= 1'b0;
            frame_match_vec_q <= '0;
        end else begin
            state_q           <= state_d;
            hist_q            <= hist_d;
            cnt_q             <= cnt_d;
            match_vec_q       <= match_vec_d;
            frame_done_q      <= frame_done_d;
            frame_match_vec_q <= frame_match_vec_d;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : gen_entry
            pattern_entry #(
                .PATTERN_BYTES (PATTERN_BYTES),
                .DATA_BYTES    (DATA_BYTES)
            ) u_entry (
                .clk          (clk),
                .rst          (rst),
                .prog_wr      (bus.prog_wr && (bus.prog_idx == IW'(gi))),
                .prog_pattern (bus.prog_pattern),
                .prog_mask    (bus.prog_mask),
                .prog_en      (bus.prog_en),
                .load         (is_sof),
                .cmp_en       (cmp_en),
                .ext          (ext),
                .ext_valid    (ext_valid),
                .hit          (hit[gi])
            );
        end

        for (genvar gi = 0; gi < PIPE_STAGES; gi++) begin : gen_pipe
            logic [DW-1:0] data_q, data_d;
            logic          valid_q, valid_d;
            if (gi == 0) begin : g_head
                assign data_d  = bus.data_in;
                assign valid_d = bus.data_valid;
            end else begin : g_body
                assign data_d  = gen_pipe[gi-1].data_q;
                assign valid_d = gen_pipe[gi-1].valid_q;
            end
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    data_q  <= '0;
                    valid_q <= 1'b0;
                end else if (bus.clear) begin
                    data_q  <= '0;
                    valid_q <= 1'b0;
                end else begin
                    data_q  <= data_d;
                    valid_q <= valid_d;
                end
            end
        end
    endgenerate

    assign bus.data_out        = gen_pipe[PIPE_STAGES-1].data_q;
    assign bus.data_out_valid  = gen_pipe[PIPE_STAGES-1].valid_q;
    assign bus.match_vec       = match_vec_q;
    assign bus.match_any       = |match_vec_q;
    assign bus.frame_done      = frame_done_q;
    assign bus.frame_match_vec = frame_match_vec_q;
endmodule
